// File: rtl/uart_rx_frame_deserializer_if.sv
// Handshake bundle between the RX bit sampler, the frame deserializer and the RX FIFO side.
// The deserializer uses the slave modport; the sampler/consumer side uses master.
interface uart_rx_frame_deserializer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6,
  parameter int LEN_WIDTH   = 4
);
  logic                   enable;
  logic                   start;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [PRESC_WIDTH-1:0] edge_count;
  logic                   sampled_bit;
  logic [LEN_WIDTH-1:0]   data_len;
  logic                   parity_odd;
  logic                   p_ready;
  logic [DATA_WIDTH-1:0]  p_data;
  logic                   p_valid;
  logic                   par_err;
  logic                   stop_err;
  logic                   overrun_err;
  logic                   busy;

  modport slave (
    input  enable, start, prescale, edge_count, sampled_bit, data_len, parity_odd, p_ready,
    output p_data, p_valid, par_err, stop_err, overrun_err, busy
  );

  modport master (
    output enable, start, prescale, edge_count, sampled_bit, data_len, parity_odd, p_ready,
    input  p_data, p_valid, par_err, stop_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_deserializer.sv
// UART RX frame deserializer: assembles data/parity/stop from strobed sampler bits, valid/ready output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
//  state    | meaning
//  S_IDLE   | waiting for a confirmed start bit
//  S_DATA   | shifting in data bits, LSB first
//  S_PARITY | sampling the parity bit (parity build only)
//  S_STOP   | sampling the stop bit; frame completes on its strobe
module uart_rx_frame_deserializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6,
  parameter int LEN_WIDTH   = 4
) (
  input logic                        clk,
  input logic                        rst,
  uart_rx_frame_deserializer_if.slave bus
);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
  logic [DATA_WIDTH-1:0]  frame_data;
  logic [LEN_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [PRESC_WIDTH-1:0] last_edge;
  logic                   par_q, par_d;
  logic                   p_valid_q, p_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stop_err_q, stop_err_d;
  logic                   overrun_q, overrun_d;
  logic                   strobe, complete, stop_bad;

  assign last_edge  = bus.prescale - PRESC_WIDTH'(1);
  assign strobe     = bus.enable & (bus.edge_count == last_edge);
  // bits enter at the MSB, so a short frame sits in the top len_q bits
  assign frame_data = shreg_q >> (LEN_MAX - len_q);

`ifndef UART_RX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = bus.parity_odd;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    par_d     = par_q;
    complete  = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_DATA;
          shreg_d   = '0;
          bit_cnt_d = '0;
          par_d     = 1'b0;
          len_d     = (bus.data_len == '0 || bus.data_len > LEN_MAX) ? LEN_MAX : bus.data_len;
        end
      end
      S_DATA: begin
        if (strobe) begin
          shreg_d   = {bus.sampled_bit, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
          if (bit_cnt_q == len_q - LEN_WIDTH'(1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (strobe) begin
          // unused shreg bits are zero, so reducing the whole register covers only the data
          par_d   = bus.sampled_bit != (^shreg_q ^ bus.parity_odd);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (strobe) begin
          complete = 1'b1;
          stop_bad = ~bus.sampled_bit;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_valid_d  = p_valid_q;
    p_data_d   = p_data_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    overrun_d  = 1'b0;
    if (complete) begin
      if (!p_valid_q || bus.p_ready) begin
        p_valid_d  = 1'b1;
        p_data_d   = frame_data;
        par_err_d  = par_q;
        stop_err_d = stop_bad;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (p_valid_q && bus.p_ready) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      len_q      <= LEN_MAX;
      par_q      <= 1'b0;
      p_valid_q  <= 1'b0;
      p_data_q   <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      par_q      <= par_d;
      p_valid_q  <= p_valid_d;
      p_data_q   <= p_data_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.p_data      = p_data_q;
  assign bus.p_valid     = p_valid_q;
  assign bus.par_err     = par_err_q;
  assign bus.stop_err    = stop_err_q;
  assign bus.overrun_err = overrun_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule
